// File: rtl/fetch.sv
// Fetch stage: owns the program counter and drives a 1-cycle-latency instruction memory.
// Presents pc_out/bubble_out aligned with the word on the memory output.
module fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_STEP  = 32'd4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        halt,
   input  logic        stall,
   input  logic        flush,
   input  logic [31:0] flush_target,
   output logic [31:0] mem_addr,
   output logic        mem_re,
   output logic [31:0] pc_out,
   output logic        bubble_out,
   output logic        halted_out,
   output logic [31:0] fetch_count
);

   localparam int unsigned AW = 32;

   localparam logic [1:0] BOOT   = 2'd0;
   localparam logic [1:0] RUN    = 2'd1;
   localparam logic [1:0] REPLAY = 2'd2;
   localparam logic [1:0] HALTED = 2'd3;

   logic [1:0]    state_q, state_d;
   logic [AW-1:0] fetch_pc_q, fetch_pc_d;
   logic [AW-1:0] pc_q, pc_d;
   logic          bubble_q, bubble_d;
   logic [AW-1:0] count_q, count_d;
   logic [AW-1:0] target;

   // Low address bits of the redirect are discarded (word aligned)
   logic unused_target_lsb;
   assign unused_target_lsb = ^flush_target[1:0];
   assign target = {flush_target[AW-1:2], 2'b00};

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= BOOT;
         fetch_pc_q <= RESET_PC;
         pc_q       <= '0;
         bubble_q   <= 1'b1;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         pc_q       <= pc_d;
         bubble_q   <= bubble_d;
         count_q    <= count_d;
      end
   end

   // Next-state and memory request, priority halt > flush > stall > normal
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      pc_d       = pc_q;
      bubble_d   = bubble_q;
      count_d    = count_q;
      mem_addr   = fetch_pc_q;
      mem_re     = 1'b1;

      if (halt || (state_q == HALTED)) begin
         mem_re   = 1'b0;
         mem_addr = pc_q;
         bubble_d = 1'b1;
         state_d  = HALTED;
      end else if (flush) begin
         mem_addr   = target;
         pc_d       = target;
         fetch_pc_d = AW'(target + PC_STEP);
         bubble_d   = 1'b0;
         count_d    = AW'(count_q + AW'(1));
         state_d    = RUN;
      end else if (stall && (state_q != BOOT)) begin
         // Re-read the held word so the memory output stays stable
         mem_addr = pc_q;
         state_d  = REPLAY;
      end else begin
         mem_addr   = fetch_pc_q;
         pc_d       = fetch_pc_q;
         fetch_pc_d = AW'(fetch_pc_q + PC_STEP);
         bubble_d   = 1'b0;
         count_d    = AW'(count_q + AW'(1));
         state_d    = RUN;
      end
   end

   assign pc_out      = pc_q;
   assign bubble_out  = bubble_q;
   assign fetch_count = count_q;
   assign halted_out  = (state_q == HALTED);

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_fetch;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        halt = 1'b0;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] flush_target = 32'h0;
   logic [31:0] mem_addr;
   logic        mem_re;
   logic [31:0] pc_out;
   logic        bubble_out;
   logic        halted_out;
   logic [31:0] fetch_count;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   fetch dut (
      .clk(clk), .rst(rst), .halt(halt), .stall(stall), .flush(flush),
      .flush_target(flush_target), .mem_addr(mem_addr), .mem_re(mem_re),
      .pc_out(pc_out), .bubble_out(bubble_out), .halted_out(halted_out),
      .fetch_count(fetch_count)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: next new address, presented address, counters, sticky halt
   logic [31:0] m_next, m_pc, m_cnt;
   logic        m_bub, m_halted, m_boot;
   logic        m_valid = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         m_next   <= 32'h0;
         m_pc     <= 32'h0;
         m_bub    <= 1'b1;
         m_cnt    <= 32'h0;
         m_halted <= 1'b0;
         m_boot   <= 1'b1;
         m_valid  <= 1'b1;
      end else if (m_valid) begin
         if (m_halted || halt) begin
            m_halted <= 1'b1;
            m_bub    <= 1'b1;
         end else if (flush) begin
            m_pc   <= flush_target & 32'hFFFF_FFFC;
            m_next <= (flush_target & 32'hFFFF_FFFC) + 32'd4;
            m_bub  <= 1'b0;
            m_cnt  <= m_cnt + 32'd1;
            m_boot <= 1'b0;
         end else if (!(stall && !m_boot)) begin
            m_pc   <= m_next;
            m_next <= m_next + 32'd4;
            m_bub  <= 1'b0;
            m_cnt  <= m_cnt + 32'd1;
            m_boot <= 1'b0;
         end
      end
   end

   // Per-cycle compare against the model, away from the active edge
   always @(negedge clk) begin
      logic        e_re;
      logic [31:0] e_addr;
      if (!rst && m_valid) begin
         e_re = !(m_halted || halt);
         if (!e_re)                 e_addr = m_pc;
         else if (flush)            e_addr = flush_target & 32'hFFFF_FFFC;
         else if (stall && !m_boot) e_addr = m_pc;
         else                       e_addr = m_next;
         chk("model mem_re", 32'(mem_re), 32'(e_re));
         chk("model mem_addr", mem_addr, e_addr);
         chk("model pc_out", pc_out, m_pc);
         chk("model bubble_out", 32'(bubble_out), 32'(m_bub));
         chk("model halted_out", 32'(halted_out), 32'(m_halted));
         chk("model fetch_count", fetch_count, m_cnt);
      end
   end

   // Apply one cycle of inputs just after posedge; return with combinational outputs settled
   task automatic drive(input logic r, input logic h, input logic f, input logic s,
                        input logic [31:0] t);
      @(posedge clk);
      #1;
      rst = r; halt = h; flush = f; stall = s; flush_target = t;
      #2;
   endtask

   initial begin
      // Reset boot
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("boot addr0", mem_addr, 32'h0);
      chk("boot re", 32'(mem_re), 32'd1);
      chk("boot pc", pc_out, 32'h0);
      chk("boot bubble", 32'(bubble_out), 32'd1);
      chk("boot count", fetch_count, 32'd0);
      chk("boot halted", 32'(halted_out), 32'd0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("boot addr4", mem_addr, 32'h4);
      chk("boot pc0 valid", 32'(bubble_out), 32'd0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("boot addr8", mem_addr, 32'h8);
      chk("boot pc4", pc_out, 32'h4);

      // Stall replay at pc_out=8
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
         chk("stall addr", mem_addr, 32'h8);
         chk("stall pc", pc_out, 32'h8);
         chk("stall count", fetch_count, 32'd3);
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("release addr", mem_addr, 32'hC);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("release pc", pc_out, 32'hC);

      // Flush at pc_out=16
      drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0103);
      chk("flush pc16", pc_out, 32'h10);
      chk("flush addr", mem_addr, 32'h100);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("flush tgt pc", pc_out, 32'h100);
      chk("flush tgt bubble", 32'(bubble_out), 32'd0);
      chk("flush next addr", mem_addr, 32'h104);

      // Flush and stall together
      drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h200);
      chk("fs addr", mem_addr, 32'h200);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
      chk("fs pc", pc_out, 32'h200);
      chk("fs replay addr", mem_addr, 32'h200);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("fs release addr", mem_addr, 32'h204);

      // Halt pulse, then flush toggling must not wake it
      drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      chk("halt re", 32'(mem_re), 32'd0);
      chk("halt addr", mem_addr, 32'h204);
      for (int i = 0; i < 10; i++) begin
         drive(1'b0, 1'b0, 1'(i % 2), 1'b0, 32'h300);
         chk("halted re", 32'(mem_re), 32'd0);
         chk("halted flag", 32'(halted_out), 32'd1);
         chk("halted bubble", 32'(bubble_out), 32'd1);
         chk("halted pc", pc_out, 32'h204);
      end
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("rehalt boot addr", mem_addr, 32'h0);
      chk("rehalt flag", 32'(halted_out), 32'd0);

      // Address wrap
      drive(1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFF8);
      chk("wrap addr0", mem_addr, 32'hFFFF_FFF8);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("wrap addr1", mem_addr, 32'hFFFF_FFFC);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("wrap addr2", mem_addr, 32'h0);
      chk("wrap pc", pc_out, 32'hFFFF_FFFC);

      // Randomized traffic, model-checked every cycle
      for (int i = 0; i < 3000; i++) begin
         logic        r, h, f, s;
         logic [31:0] t;
         r = ($urandom_range(0, 199) == 0);
         h = ($urandom_range(0, 149) == 0);
         f = ($urandom_range(0, 5) == 0);
         s = ($urandom_range(0, 2) == 0);
         t = $urandom;
         if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF0 | (t & 32'hF);
         drive(r, h, f, s, t);
      end

      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      @(posedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
